// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU (src0) and the
// load unit (src1) using round-robin valid/ready arbitration. The winning write
// is registered and presented to the register file one cycle after acceptance.
// A pending-write scoreboard is set when an instruction issues and cleared when
// its write reaches the register file. The scoreboard drives a RAW hazard flag
// for the two decode read ports.

module regfile_wb_arbiter #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src0_valid,
  input  logic [4:0]       src0_addr,
  input  logic [DW-1:0]    src0_data,
  output logic             src0_ready,
  input  logic             src1_valid,
  input  logic [4:0]       src1_addr,
  input  logic [DW-1:0]    src1_data,
  output logic             src1_ready,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic             hazard,
  output logic             wr_ena,
  output logic [4:0]       wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [NREGS-1:0] pending
);

  localparam int AW = 5;

  // Decode a register index into a one-hot scoreboard mask.
  function automatic logic [NREGS-1:0] addr_onehot(input logic [AW-1:0] a);
    logic [NREGS-1:0] v;
    v    = {NREGS{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  // Registered state
  logic             rr_q;        // 0: src0 has priority, 1: src1 has priority
  logic             rr_d;
  logic             wr_ena_q;
  logic             wr_ena_d;
  logic [AW-1:0]    wr_addr_q;
  logic [AW-1:0]    wr_addr_d;
  logic [DW-1:0]    wr_data_q;
  logic [DW-1:0]    wr_data_d;
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Combinational signals
  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic             contend_s;
  logic [AW-1:0]    win_addr_s;
  logic [DW-1:0]    win_data_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;

  assign contend_s = src0_valid & src1_valid;

  // Round-robin grant; nothing is granted while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (contend_s) begin
      grant0_s = (rr_q == 1'b0);
      grant1_s = (rr_q == 1'b1);
    end else begin
      grant0_s = src0_valid;
      grant1_s = src1_valid;
    end
  end

  assign src0_ready = grant0_s;
  assign src1_ready = grant1_s;
  assign accept_s   = grant0_s | grant1_s;

  // Select the address/data of whichever source won this cycle.
  always_comb begin
    win_addr_s = src0_addr;
    win_data_s = src0_data;
    if (grant1_s) begin
      win_addr_s = src1_addr;
      win_data_s = src1_data;
    end else begin
      win_addr_s = src0_addr;
      win_data_s = src0_data;
    end
  end

  // Priority moves to the loser only when both sources competed; a lone
  // requester never disturbs the rotation.
  always_comb begin
    rr_d = rr_q;
    if (contend_s && accept_s) begin
      rr_d = grant0_s ? 1'b1 : 1'b0;
    end else begin
      rr_d = rr_q;
    end
  end

  // Next registered write: an accept to x0 completes the handshake but does
  // not enable the register-file write. Address/data hold when idle.
  always_comb begin
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept_s) begin
      wr_ena_d  = (win_addr_s != 5'd0);
      wr_addr_d = win_addr_s;
      wr_data_d = win_data_s;
    end else begin
      wr_ena_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // Scoreboard update: an issue sets its bit, a write leaving the port clears
  // its bit, and a same-edge set beats the clear (a newer producer is in flight).
  always_comb begin
    set_mask_s = {NREGS{1'b0}};
    clr_mask_s = {NREGS{1'b0}};
    if (issue_valid) begin
      set_mask_s = addr_onehot(issue_rd);
    end else begin
      set_mask_s = {NREGS{1'b0}};
    end
    if (wr_ena_q) begin
      clr_mask_s = addr_onehot(wr_addr_q);
    end else begin
      clr_mask_s = {NREGS{1'b0}};
    end
    pending_d    = set_mask_s | (pending_q & ~clr_mask_s);
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset; reset drops any
  // in-flight write and empties the scoreboard.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q      <= 1'b0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= {DW{1'b0}};
      pending_q <= {NREGS{1'b0}};
    end else begin
      rr_q      <= rr_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

  // Hazard has no bypass: an accept in the current cycle does not mask it.
  assign hazard = pending_q[rd_addr1] | pending_q[rd_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed checks with hand-computed values,
// then randomized traffic compared every cycle against a behavioural model.

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        src0_valid = 1'b0;
  logic [4:0]  src0_addr  = 5'd0;
  logic [31:0] src0_data  = 32'd0;
  logic        src0_ready;
  logic        src1_valid = 1'b0;
  logic [4:0]  src1_addr  = 5'd0;
  logic [31:0] src1_data  = 32'd0;
  logic        src1_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [4:0]  rd_addr1 = 5'd0;
  logic [4:0]  rd_addr2 = 5'd0;
  logic        hazard;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.NREGS(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data), .src1_ready(src1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard(hazard),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State as seen by the register file after the last edge.
  int          m_prio    = 0;       // which source wins a tie
  bit [31:0]   m_pend    = 32'd0;   // registers with a write in flight
  bit          m_wr_ena  = 1'b0;
  bit [4:0]    m_wr_addr = 5'd0;
  bit [31:0]   m_wr_data = 32'd0;
  bit          m_g0 = 1'b0;          // model grant for the current input set
  bit          m_g1 = 1'b0;

  // Compare DUT outputs against the model mid-cycle, then advance the model
  // to what the coming edge must produce.
  always @(negedge clk) begin
    bit       e_haz;
    bit [4:0] a;
    bit [31:0] d;
    if (!rst) begin
      m_g0 = 1'b0; m_g1 = 1'b0;
    end else if (src0_valid && src1_valid) begin
      m_g0 = (m_prio == 0); m_g1 = (m_prio == 1);
    end else begin
      m_g0 = src0_valid; m_g1 = src1_valid;
    end
    e_haz = m_pend[rd_addr1] | m_pend[rd_addr2];
    chk("m_ready0", 64'(src0_ready), 64'(m_g0));
    chk("m_ready1", 64'(src1_ready), 64'(m_g1));
    chk("m_hazard", 64'(hazard), 64'(e_haz));
    chk("m_wr_ena", 64'(wr_ena), 64'(m_wr_ena));
    chk("m_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    chk("m_wr_data", 64'(wr_data), 64'(m_wr_data));
    chk("m_pending", 64'(pending), 64'(m_pend));
    if (!rst) begin
      m_prio = 0; m_pend = 32'd0; m_wr_ena = 1'b0; m_wr_addr = 5'd0; m_wr_data = 32'd0;
    end else begin
      if (m_wr_ena) m_pend[m_wr_addr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
      if (m_g0 || m_g1) begin
        a = m_g0 ? src0_addr : src1_addr;
        d = m_g0 ? src0_data : src1_data;
        m_wr_ena = (a != 5'd0); m_wr_addr = a; m_wr_data = d;
      end else begin
        m_wr_ena = 1'b0;
      end
      if (src0_valid && src1_valid) m_prio = m_g0 ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    else return 5'($urandom_range(0, 7));
  endfunction

  logic [4:0]  exp_addr [4];
  logic        exp_r0   [4];

  initial begin
    exp_addr[0] = 5'd0; exp_addr[1] = 5'd3; exp_addr[2] = 5'd4; exp_addr[3] = 5'd3;
    exp_r0[0] = 1'b1; exp_r0[1] = 1'b0; exp_r0[2] = 1'b1; exp_r0[3] = 1'b0;

    // Reset with both sources requesting
    rst = 1'b0;
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'hA0A0_0003;
    src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 32'hB1B1_0004;
    tick(); #1;
    chk("rst_ready0", 64'(src0_ready), 64'd0);
    chk("rst_ready1", 64'(src1_ready), 64'd0);
    chk("rst_wr_ena", 64'(wr_ena), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    tick();
    rst = 1'b1;

    // Contention: grants alternate src0, src1, ...; writes 3, 4, 3, 4
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      chk("cont_ready0", 64'(src0_ready), 64'(exp_r0[k]));
      chk("cont_ready1", 64'(src1_ready), 64'(!exp_r0[k]));
      if (k > 0) chk("cont_wr_addr", 64'(wr_addr), 64'(exp_addr[k]));
    end
    tick();
    src0_valid = 1'b0;
    src1_valid = 1'b1; src1_addr = 5'd5; src1_data = 32'hDEAD_BEEF;
    #1;
    chk("cont_last_addr", 64'(wr_addr), 64'd4);
    chk("single_ready1", 64'(src1_ready), 64'd1);
    chk("single_ready0", 64'(src0_ready), 64'd0);
    tick();
    src1_valid = 1'b0;
    #1;
    chk("single_wr_ena", 64'(wr_ena), 64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'd5);
    chk("single_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    tick();
    // x0 write
    src0_valid = 1'b1; src0_addr = 5'd0; src0_data = 32'h0000_1234;
    #1;
    chk("single_idle_ena", 64'(wr_ena), 64'd0);
    chk("single_hold_addr", 64'(wr_addr), 64'd5);
    chk("x0_ready0", 64'(src0_ready), 64'd1);
    tick();
    src0_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("x0_wr_ena", 64'(wr_ena), 64'd0);
    chk("x0_pending", 64'(pending), 64'd0);

    // Scoreboard: issue 7, then write 7
    tick();
    issue_valid = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'h0000_0077;
    #1;
    chk("sb_pending7", 64'(pending), 64'h80);
    chk("sb_hazard_nobypass", 64'(hazard), 64'd1);
    chk("sb_ready0", 64'(src0_ready), 64'd1);
    tick();
    src0_valid = 1'b0;
    #1;
    chk("sb_wr_ena", 64'(wr_ena), 64'd1);
    chk("sb_still_pending", 64'(pending), 64'h80);
    tick();
    #1;
    chk("sb_cleared", 64'(pending), 64'd0);
    chk("sb_hazard_clear", 64'(hazard), 64'd0);

    // Set/clear collision on register 9
    src0_valid = 1'b1; src0_addr = 5'd9; src0_data = 32'h0000_0099;
    tick();
    src0_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    src1_valid = 1'b1; src1_addr = 5'd9; src1_data = 32'h0000_9999;
    #1;
    chk("coll_pending9", 64'(pending), 64'h200);
    tick();
    src1_valid = 1'b0;
    tick();
    #1;
    chk("coll_cleared", 64'(pending), 64'd0);

    // Reset mid-operation drops the in-flight write
    src0_valid = 1'b1; src0_addr = 5'd10; src0_data = 32'h0000_00AA;
    issue_valid = 1'b1; issue_rd = 5'd11;
    tick();
    src0_valid = 1'b0; issue_valid = 1'b0;
    #1;
    chk("mid_wr_ena", 64'(wr_ena), 64'd1);
    chk("mid_pending", 64'(pending), 64'h800);
    rst = 1'b0;
    tick();
    #1;
    chk("mid_rst_ena", 64'(wr_ena), 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    rst = 1'b1;

    // Randomized traffic; a source not accepted holds its request stable
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) != 0);
      if (!(src0_valid && !m_g0)) begin
        src0_valid = ($urandom_range(0, 2) != 0);
        src0_addr  = rand_addr();
        src0_data  = $urandom();
      end
      if (!(src1_valid && !m_g1)) begin
        src1_valid = ($urandom_range(0, 2) != 0);
        src1_addr  = rand_addr();
        src1_data  = $urandom();
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = rand_addr();
      rd_addr1    = rand_addr();
      rd_addr2    = rand_addr();
    end
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the register file's single write port and shares it between two writeback sources: src0 (ALU) and src1 (load unit).
- Uses valid/ready handshakes with round-robin arbitration; the write is registered and driven one cycle after acceptance.
- Keeps a 32-entry pending-write scoreboard, set at issue and cleared when the write reaches the register file.
- From the scoreboard it flags read-after-write hazards on the two decode read addresses so the pipeline can stall.

Parameters:
- NREGS, 32, number of architectural registers and scoreboard entries. Fixed at 32; the address width is 5.
- DW, 32, writeback data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- src0_valid  in  1  ALU writeback request
- src0_addr  in  5  ALU destination register
- src0_data  in  DW  ALU result
- src0_ready  out  1  ALU request accepted this cycle
- src1_valid  in  1  load writeback request
- src1_addr  in  5  load destination register
- src1_data  in  DW  load result
- src1_ready  out  1  load request accepted this cycle
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_rd  in  5  destination register of the issuing instruction
- rd_addr1  in  5  decode read address 1
- rd_addr2  in  5  decode read address 2
- hazard  out  1  rd_addr1 or rd_addr2 has a write still in flight
- wr_ena  out  1  write enable to the register file
- wr_addr  out  5  register-file write address
- wr_data  out  DW  register-file write data
- pending  out  32  scoreboard bit vector (debug/observe)

Behaviour:
- Reset (rst==0 at a rising edge):
  - wr_ena=0, wr_addr=0, wr_data=0, pending=0.
  - Round-robin pointer rr=0, meaning src0 has priority.
  - Reset overrides all inputs that edge; any in-flight registered write is dropped.
- Arbitration (combinational within the cycle):
  - Only one valid: it is granted.
  - Both valid: the source selected by rr is granted.
  - srcN_ready = grantN. At most one ready is high per cycle, and ready never asserts without its valid.
  - Accept = valid && ready.
- rr update:
  - Only when both sources were valid and one was accepted: rr <= index of the loser.
  - Otherwise rr is held, so a lone requester never changes priority.
- Write path (1-cycle latency):
  - On accept, the next edge loads wr_addr and wr_data from the winning source.
  - wr_ena <= 1 if the accepted addr != 0; an accept to x0 completes the handshake but gives wr_ena <= 0.
  - No accept: wr_ena <= 0. wr_addr and wr_data hold their last value.
- Throughput: one write per cycle. The losing source keeps valid high and holds addr/data stable until accepted; data must not change while valid && !ready.
- Scoreboard, per bit r, at each edge:
  - set_r = issue_valid && issue_rd==r && r!=0.
  - clr_r = wr_ena && wr_addr==r, i.e. cleared at the same edge the register file captures the write.
  - set_r wins over clr_r on the same edge (a newer producer is in flight).
  - pending[0] is always 0.
- hazard (combinational) = pending[rd_addr1] | pending[rd_addr2].
  - Address 0 never raises hazard.
  - A register whose write is captured at edge E has its pending bit clear from E. A read presented after E returns the new value, because the register-file read is itself registered.
- No bypass: hazard is not masked by an accept happening in the current cycle.
- Duplicate issue to an already-pending register leaves the bit set; one writeback clears it. The pipeline issues in order, so this is the required behaviour.
- Reset mid-operation: a pending write whose wr_ena was high at the reset edge is not delivered; the scoreboard clears.

Test Plan:
- Reset: rst=0 for 2 cycles with both srcs valid → ready=0/0 during reset, wr_ena=0, pending=0; after release src0 is granted first.
- Single source: src1_valid=1, addr=5, data=0xDEADBEEF for 1 cycle → src1_ready=1 that cycle; next cycle wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle wr_ena=0.
- Contention: both valid continuously with addrs 3/4 → grants alternate src0, src1, src0, ...; src1 held stable while not ready; wr_addr sequence 3, 4, 3, 4.
- x0 write: src0_valid, addr=0, data=0x1234 → src0_ready=1, next cycle wr_ena=0, pending stays 0.
- Scoreboard: issue_rd=7 → pending[7]=1 and rd_addr1=7 gives hazard=1; src0 writes addr 7 → pending[7] clears at the wr_ena=1 edge and hazard=0 the cycle after; rd_addr2=0 never raises hazard.
- Set/clear collision: issue_valid with issue_rd=9 on the same edge wr_ena=1 with wr_addr=9 → pending[9] stays 1, and a later write to 9 clears it.
